light_serial_tx: RTL and testbench

//  Consumes the 24-bit colour word driven onto the light bus by the lights selector and transmits it

---
 rtl/light_serial_tx.sv | 129 ++++++++++++
 tb/tb_light_serial_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/light_serial_tx.sv
// Serialises a captured 24-bit colour word to a shift-register LED driver (SDO/SCLK/LATCH, MSB first).
// The frame is latched on an accepted load, so later bus changes cannot disturb a frame in flight.
module light_serial_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] light,
  input  logic        load,
  output logic        ready,
  output logic        sdo,
  output logic        sclk,
  output logic        latch,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [23:0] shreg_q, shreg_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        sdo_q, sdo_d;
  logic        sclk_q, sclk_d;
  logic        latch_q, latch_d;
  logic        done_q, done_d;
  logic        div_end;

  assign div_end = (div_cnt_q == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sdo_q     <= 1'b0;
      sclk_q    <= 1'b0;
      latch_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sdo_q     <= sdo_d;
      sclk_q    <= sclk_d;
      latch_q   <= latch_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sdo_d     = sdo_q;
    sclk_d    = sclk_q;
    latch_d   = latch_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        sdo_d   = 1'b0;
        sclk_d  = 1'b0;
        latch_d = 1'b0;
        if (load) begin
          shreg_d   = light;
          bit_cnt_d = 5'd23;
          div_cnt_d = '0;
          sdo_d     = light[23];
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (!div_end) begin
          div_cnt_d = div_cnt_q + 8'd1;
        end else begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // End of the high phase: sdo moves only here, with sclk going low.
            sclk_d = 1'b0;
            if (bit_cnt_q != 5'd0) begin
              shreg_d   = {shreg_q[22:0], 1'b0};
              sdo_d     = shreg_q[22];
              bit_cnt_d = bit_cnt_q - 5'd1;
            end else begin
              sdo_d   = 1'b0;
              latch_d = 1'b1;
              state_d = LATCH;
            end
          end
        end
      end

      LATCH: begin
        if (!div_end) begin
          div_cnt_d = div_cnt_q + 8'd1;
        end else begin
          div_cnt_d = '0;
          latch_d   = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready = (state_q == IDLE);
  assign sdo   = sdo_q;
  assign sclk  = sclk_q;
  assign latch = latch_q;
  assign done  = done_q;

endmodule

// File: tb/tb_light_serial_tx.sv
// Bench for light_serial_tx: per-cycle comparison against a frame-timing model, frame table,
// hand sequences for mid-frame load, continuous load, mid-frame reset and a CLK_DIV=1 build.
module tb_light_serial_tx;

  localparam int C = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] light, light1;
  logic        load, load1;
  logic        ready, sdo, sclk, latch, done;
  logic        ready1, sdo1, sclk1, latch1, done1;

  always #5 clk = ~clk;

  light_serial_tx #(.CLK_DIV(C)) dut (
    .clk(clk), .rst(rst), .light(light), .load(load),
    .ready(ready), .sdo(sdo), .sclk(sclk), .latch(latch), .done(done)
  );

  light_serial_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .light(light1), .load(load1),
    .ready(ready1), .sdo(sdo1), .sclk(sclk1), .latch(latch1), .done(done1)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: a frame is just "cycles since accept" plus the captured word.
  bit          m_act = 1'b0;
  int          m_n = 0;
  logic [23:0] m_w = '0;

  logic [23:0] cap = '0, cap1 = '0;
  int          rises = 0, rises1 = 0, done_cnt = 0, latch_cnt = 0, latch_rise_cyc = 0;
  int          latch1_cnt = 0;
  logic        prev_sclk = 1'b0, prev_latch = 1'b0, prev_sclk1 = 1'b0, prev_latch1 = 1'b0;

  typedef struct {
    logic [23:0] light;
    logic [23:0] chg;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0] model_out();
    logic r, d, s, l, dn;
    if (!m_act) return 5'b10000;
    r  = (m_n >= 49 * C);
    s  = (m_n < 48 * C) && (((m_n / C) % 2) == 1);
    d  = (m_n < 48 * C) ? m_w[23 - (m_n / (2 * C))] : 1'b0;
    l  = (m_n >= 48 * C) && (m_n < 49 * C);
    dn = (m_n == 49 * C);
    return {r, d, s, l, dn};
  endfunction

  // One clock: update model at the edge, sample DUTs 1 time unit later, return at the falling edge.
  task automatic tick();
    bit mrdy;
    @(posedge clk);
    cyc++;
    mrdy = !m_act || (m_n >= 49 * C);
    if (!rst) begin
      m_act = 1'b0;
      m_n   = 0;
    end else if (mrdy && load) begin
      m_act = 1'b1;
      m_n   = 0;
      m_w   = light;
    end else if (m_act) begin
      m_n++;
      if (m_n > 49 * C) m_act = 1'b0;
    end
    #1;
    if (sclk && !prev_sclk) begin
      cap = {cap[22:0], sdo};
      rises++;
    end
    if (latch && !prev_latch) begin
      latch_cnt++;
      latch_rise_cyc = cyc;
    end
    if (done) done_cnt++;
    if (sclk1 && !prev_sclk1) begin
      cap1 = {cap1[22:0], sdo1};
      rises1++;
    end
    if (latch1 && !prev_latch1) latch1_cnt++;
    prev_sclk   = sclk;
    prev_latch  = latch;
    prev_sclk1  = sclk1;
    prev_latch1 = latch1;
    check("cycle_outputs", {27'd0, ready, sdo, sclk, latch, done}, {27'd0, model_out()});
    @(negedge clk);
  endtask

  task automatic wait_done(input int bound, output int dc, output bit ok);
    ok = 1'b0;
    dc = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done) begin
        dc = cyc;
        ok = 1'b1;
        return;
      end
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  // Send one frame; at T0+50 drive chg onto the bus with load high (must be ignored).
  task automatic send_frame(input logic [23:0] v, input logic [23:0] chg, input logic [23:0] exp);
    int t0, r0, dc, dcnt0;
    bit ok;
    light = v;
    load  = 1'b1;
    tick();
    t0 = cyc;
    load = 1'b0;
    r0 = rises;
    ok = 1'b0;
    dc = 0;
    for (int i = 0; i < 300; i++) begin
      if (cyc == t0 + 50) begin
        light = chg;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
      if (done) begin
        dc = cyc;
        ok = 1'b1;
        break;
      end
    end
    load = 1'b0;
    check("frame_done_seen", {31'd0, ok}, 32'd1);
    check("frame_bits", {8'd0, cap}, {8'd0, exp});
    check("frame_rises", rises - r0, 32'd24);
    check("frame_latch_start", latch_rise_cyc - t0, 48 * C);
    check("frame_done_time", dc - t0, 49 * C);
    check("frame_ready_at_done", {31'd0, ready}, 32'd1);
    dcnt0 = done_cnt;
    r0 = rises;
    repeat (20) tick();
    check("no_second_frame_rises", rises - r0, 32'd0);
    check("no_second_frame_done", done_cnt - dcnt0, 32'd0);
  endtask

  initial begin
    int d_prev, dc, t0, dcnt0, lcnt0;
    bit ok;

    rst    = 1'b0;
    load   = 1'b1;
    light  = 24'hA5C3F0;
    load1  = 1'b0;
    light1 = '0;

    // Reset held with load high: nothing may move.
    repeat (5) tick();
    check("reset_outputs", {27'd0, ready, sdo, sclk, latch, done}, 32'h10);
    check("reset_no_sclk", rises, 32'd0);
    check("reset_ready1", {31'd0, ready1}, 32'd1);
    load = 1'b0;
    rst  = 1'b1;
    repeat (3) tick();

    tbl[0] = '{light: 24'hA5C3F0, chg: 24'h000000, exp: 24'hA5C3F0};
    tbl[1] = '{light: 24'h000000, chg: 24'hFFFFFF, exp: 24'h000000};
    tbl[2] = '{light: 24'hFFFFFF, chg: 24'h0F0F0F, exp: 24'hFFFFFF};
    tbl[3] = '{light: 24'h800001, chg: 24'h7FFFFE, exp: 24'h800001};
    for (int i = 0; i < 4; i++) send_frame(tbl[i].light, tbl[i].chg, tbl[i].exp);

    // Continuous load: frames follow each other, next accept on the done cycle.
    light = 24'h123456;
    load  = 1'b1;
    wait_done(300, d_prev, ok);
    check("cont_first_word", {8'd0, cap}, 32'h123456);
    for (int f = 0; f < 3; f++) begin
      wait_done(300, dc, ok);
      check("cont_period", dc - d_prev, 49 * C + 1);
      check("cont_word", {8'd0, cap}, 32'h123456);
      d_prev = dc;
    end
    load = 1'b0;
    repeat (5) tick();

    // Reset in the middle of a frame.
    light = 24'hFFFFFF;
    load  = 1'b1;
    tick();
    t0 = cyc;
    load = 1'b0;
    while (cyc < t0 + 100) tick();
    dcnt0 = done_cnt;
    lcnt0 = latch_cnt;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", {27'd0, ready, sdo, sclk, latch, done}, 32'h10);
    repeat (2) tick();
    rst = 1'b1;
    repeat (200) tick();
    check("abort_no_latch", latch_cnt - lcnt0, 32'd0);
    check("abort_no_done", done_cnt - dcnt0, 32'd0);
    send_frame(24'hFFFFFF, 24'h000000, 24'hFFFFFF);

    // Randomised traffic, including occasional held load and short resets.
    for (int i = 0; i < 4000; i++) begin
      light = 24'($urandom);
      if ($urandom_range(0, 39) == 0) load = ~load;
      rst = ($urandom_range(0, 1499) != 0);
      tick();
    end
    rst  = 1'b1;
    load = 1'b0;
    repeat (250) tick();

    // CLK_DIV=1 instance.
    light1 = 24'h800001;
    load1  = 1'b1;
    tick();
    t0 = cyc;
    load1 = 1'b0;
    light1 = 24'h7FFFFE;
    lcnt0 = latch1_cnt;
    ok = 1'b0;
    dc = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done1) begin
        dc = cyc;
        ok = 1'b1;
        break;
      end
    end
    check("div1_done_seen", {31'd0, ok}, 32'd1);
    check("div1_latency", dc - t0, 32'd49);
    check("div1_word", {8'd0, cap1}, 32'h800001);
    check("div1_first_bit", {31'd0, cap1[23]}, 32'd1);
    check("div1_last_bit", {31'd0, cap1[0]}, 32'd1);
    check("div1_rises", rises1, 32'd24);
    check("div1_latch_once", latch1_cnt - lcnt0, 32'd1);
    check("div1_ready", {31'd0, ready1}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
